// File: rtl/bumpy_menu_pkg.sv
// Shared types and widths for the level-select menu and its graphics block.
// Pure declarations; no timing or flow-control behaviour.
package bumpy_menu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    COUNTDOWN,
    DONE,
    WAIT_EXIT
  } menu_state_t;

  localparam int LVL_W = 2;
  localparam int CNT_W = 4;

endpackage

// File: rtl/key_edge_detect.sv
// Key press detector: one history register, press = key & ~key_d.
// Latency: press is combinational from key; no backpressure.
module key_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic key,
  output logic press
);

  logic key_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) key_d <= 1'b0;
    else         key_d <= key;
  end

  assign press = key & ~key_d;

endmodule

// File: rtl/level_menu_controller.sv
// Level-select menu: wrap-around cursor, idle auto-confirm, start countdown, one menu_comp pulse.
// Latency: registered outputs, 1 cycle after key/strobe; no backpressure. Option: LEVEL_MENU_AUTO_ADVANCE_EN.
module level_menu_controller
  import bumpy_menu_pkg::*;
#(
  parameter int NUM_LEVELS       = 4,
  parameter int COUNTDOWN_SEC    = 3,
  parameter int IDLE_TIMEOUT_SEC = 10
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             one_sec,
  input  logic             menu_screen,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_enter,
`ifdef LEVEL_MENU_AUTO_ADVANCE_EN
  input  logic             level_comp,
`endif
  output logic             menu_comp,
  output logic [LVL_W-1:0] lvl_selected,
  output logic [CNT_W-1:0] countdown_val,
  output logic             countdown_active
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0] CD_INIT = CNT_W'(COUNTDOWN_SEC);
  localparam bit               TO_EN   = (IDLE_TIMEOUT_SEC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((IDLE_TIMEOUT_SEC == 0) ? 0 : IDLE_TIMEOUT_SEC - 1);

  menu_state_t      state, state_nxt;
  logic [LVL_W-1:0] lvl_nxt;
  logic [CNT_W-1:0] cd_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_nxt;
  logic             up_p, dn_p, en_p;
  logic             any_press, auto_confirm, confirm;

  key_edge_detect u_up    (.clk(clk), .resetN(resetN), .key(key_up),    .press(up_p));
  key_edge_detect u_down  (.clk(clk), .resetN(resetN), .key(key_down),  .press(dn_p));
  key_edge_detect u_enter (.clk(clk), .resetN(resetN), .key(key_enter), .press(en_p));

  assign any_press = up_p | dn_p | en_p;
  // Timeout fires on the strobe that would bring the counter up to IDLE_TIMEOUT_SEC.
  assign auto_confirm = TO_EN && (state == SELECT) && one_sec && !any_press && (idle_cnt == TO_LAST);
  assign confirm      = en_p | auto_confirm;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (menu_screen) state_nxt = SELECT;
      SELECT: begin
        if (!menu_screen)  state_nxt = IDLE;
        else if (confirm)  state_nxt = (COUNTDOWN_SEC == 0) ? DONE : COUNTDOWN;
      end
      COUNTDOWN: begin
        if (!menu_screen)                                state_nxt = IDLE;
        else if (one_sec && countdown_val == CNT_W'(1))  state_nxt = DONE;
      end
      DONE:      state_nxt = WAIT_EXIT;
      WAIT_EXIT: if (!menu_screen) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lvl_nxt  = lvl_selected;
    cd_nxt   = countdown_val;
    idle_nxt = '0;
    case (state)
      SELECT: begin
        if (!menu_screen) begin
          cd_nxt = '0;
        end else if (confirm) begin
          cd_nxt = CD_INIT;
        end else begin
          if (up_p && !dn_p)
            lvl_nxt = (lvl_selected == '0) ? LVL_MAX : lvl_selected - 1'b1;
          else if (dn_p && !up_p)
            lvl_nxt = (lvl_selected == LVL_MAX) ? '0 : lvl_selected + 1'b1;
          if (any_press)
            idle_nxt = '0;
          else if (one_sec && idle_cnt != '1)
            idle_nxt = idle_cnt + 1'b1;
          else
            idle_nxt = idle_cnt;
        end
      end
      COUNTDOWN: begin
        if (!menu_screen) cd_nxt = '0;
        else if (one_sec) cd_nxt = countdown_val - 1'b1;
      end
      default: ;
    endcase
`ifdef LEVEL_MENU_AUTO_ADVANCE_EN
    // Finished a level: open the next menu one level further on.
    if (level_comp && state != SELECT && lvl_selected != LVL_MAX)
      lvl_nxt = lvl_selected + 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lvl_selected     <= '0;
      countdown_val    <= '0;
      idle_cnt         <= '0;
      menu_comp        <= 1'b0;
      countdown_active <= 1'b0;
    end else begin
      lvl_selected     <= lvl_nxt;
      countdown_val    <= cd_nxt;
      idle_cnt         <= idle_nxt;
      menu_comp        <= (state_nxt == DONE);
      countdown_active <= (state_nxt == COUNTDOWN);
    end
  end

endmodule

// File: tb/tb_level_menu_controller.sv
// Scoreboard bench: directed test-plan sequences plus random traffic against a behavioural menu model.
module tb_level_menu_controller;

  localparam int N  = 4;
  localparam int CD = 3;
  localparam int TO = 10;

  localparam int OFF = 0, PICK = 1, COUNT = 2, FIRE = 3, HOLD = 4;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       one_sec = 1'b0, menu_screen = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_enter = 1'b0;
  logic       level_comp = 1'b0;
  logic       menu_comp, countdown_active;
  logic [1:0] lvl_selected;
  logic [3:0] countdown_val;

  level_menu_controller #(.NUM_LEVELS(N), .COUNTDOWN_SEC(CD), .IDLE_TIMEOUT_SEC(TO)) dut (
    .clk(clk), .resetN(resetN), .one_sec(one_sec), .menu_screen(menu_screen),
    .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
`ifdef LEVEL_MENU_AUTO_ADVANCE_EN
    .level_comp(level_comp),
`endif
    .menu_comp(menu_comp), .lvl_selected(lvl_selected),
    .countdown_val(countdown_val), .countdown_active(countdown_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    int cd;
    int comp;
    int act;
  } exp_t;

  exp_t exp_q[$];
  int   comp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: a menu session as a stage, a cursor, seconds remaining and seconds since last press.
  int m_stage = OFF, m_lvl = 0, m_cd = 0, m_quiet = 0;
  bit pu = 0, pd = 0, pe = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stage = OFF; m_lvl = 0; m_cd = 0; m_quiet = 0;
    pu = 0; pd = 0; pe = 0;
  endtask

  task automatic model_step(input bit ms, input bit up, input bit dn, input bit en,
                            input bit os, input bit lc);
    bit up_p, dn_p, en_p, go;
    int old;
    up_p = up && !pu; dn_p = dn && !pd; en_p = en && !pe;
    pu = up; pd = dn; pe = en;
    old = m_stage;
    case (old)
      OFF: if (ms) begin m_stage = PICK; m_quiet = 0; end
      PICK: begin
        if (!ms) m_stage = OFF;
        else begin
          if (up_p || dn_p || en_p) m_quiet = 0;
          else if (os) m_quiet++;
          go = en_p || (TO != 0 && m_quiet == TO);
          if (go) begin
            m_quiet = 0;
            if (CD == 0) m_stage = FIRE;
            else begin m_stage = COUNT; m_cd = CD; end
          end else if (up_p != dn_p) begin
            m_lvl = up_p ? (m_lvl + N - 1) % N : (m_lvl + 1) % N;
          end
        end
      end
      COUNT: begin
        if (!ms) begin m_stage = OFF; m_cd = 0; end
        else if (os) begin
          m_cd--;
          if (m_cd == 0) m_stage = FIRE;
        end
      end
      FIRE: m_stage = HOLD;
      default: if (!ms) m_stage = OFF;
    endcase
`ifdef LEVEL_MENU_AUTO_ADVANCE_EN
    if (lc && old != PICK && m_lvl < N - 1) m_lvl++;
`endif
    if (m_stage == FIRE) comp_q.push_back(m_lvl);
    exp_q.push_back('{lvl: m_lvl, cd: m_cd, comp: int'(m_stage == FIRE), act: int'(m_stage == COUNT)});
  endtask

  task automatic step(input bit ms, input bit up, input bit dn, input bit en,
                      input bit os, input bit lc = 1'b0);
    @(negedge clk);
    menu_screen = ms; key_up = up; key_down = dn; key_enter = en;
    one_sec = os; level_comp = lc;
    model_step(ms, up, dn, en, os, lc);
  endtask

  task automatic quiet(input bit ms, input int n);
    for (int i = 0; i < n; i++) step(ms, 0, 0, 0, 0);
  endtask

  task automatic press(input bit up, input bit dn, input bit en);
    step(1, up, dn, en, 0);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic second();
    quiet(1, 3);
    step(1, 0, 0, 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lvl"},    int'(lvl_selected), 0);
    check({tag, "_cd"},     int'(countdown_val), 0);
    check({tag, "_comp"},   int'(menu_comp), 0);
    check({tag, "_active"}, int'(countdown_active), 0);
  endtask

  // Monitor: one expectation per driven cycle; each menu_comp pulse consumes a confirmed level.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("lvl_selected",     int'(lvl_selected), e.lvl);
      check("countdown_val",    int'(countdown_val), e.cd);
      check("menu_comp",        int'(menu_comp), e.comp);
      check("countdown_active", int'(countdown_active), e.act);
    end
    if (menu_comp) begin
      if (comp_q.size() == 0) check("comp_unexpected", 1, 0);
      else                    check("comp_level", int'(lvl_selected), comp_q.pop_front());
    end
  end

  initial begin
    bit ms, u, d, en;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    resetN = 1'b1;

    // Down x3, enter, three seconds of countdown, then linger in the menu.
    quiet(1, 2);
    press(0, 1, 0); press(0, 1, 0); press(0, 1, 0);
    press(0, 0, 1);
    second(); second(); second();
    quiet(1, 6);
    quiet(0, 2);

    // Wrap-around both ways.
    quiet(1, 2);
    press(0, 1, 0);
    press(1, 0, 0);
    press(1, 1, 0);
    quiet(0, 2);

    // Enter held across entry, then re-press; enter+down together; abort at countdown 2.
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    quiet(1, 2);
    press(0, 0, 1);
    second();
    quiet(0, 2);
    quiet(1, 2);
    press(0, 1, 1);
    second();
    quiet(0, 3);

    // Idle timeout, and a press at strobe 9 that defers it.
    quiet(1, 2);
    for (int s = 0; s < TO; s++) second();
    second(); second(); second();
    quiet(1, 2);
    quiet(0, 2);
    quiet(1, 2);
    for (int s = 0; s < TO - 2; s++) second();
    quiet(1, 3);
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    second();
    quiet(1, 2);

    // Asynchronous reset mid-countdown.
    press(0, 0, 1);
    quiet(1, 2);
    @(negedge clk);
    resetN = 1'b0; menu_screen = 0; key_up = 0; key_down = 0; key_enter = 0; one_sec = 0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    comp_q.delete();
    @(negedge clk);
    resetN = 1'b1;

    // Random traffic: busy keys, then sparse keys so timeouts also occur.
    ms = 0; u = 0; d = 0; en = 0;
    for (int i = 0; i < 6000; i++) begin
      int kp;
      kp = (i < 3000) ? 12 : 300;
      if ($urandom_range(0, 149) == 0) ms = !ms;
      if ($urandom_range(0, kp - 1) == 0) u = !u;
      if ($urandom_range(0, kp - 1) == 0) d = !d;
      if ($urandom_range(0, kp - 1) == 0) en = !en;
      step(ms, u, d, en, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
    end

    quiet(0, 3);
    @(posedge clk);
    #2;
    check("pending_comp", comp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/level_menu_controller.md
Name: level_menu_controller

Overview:
- Player-facing level-select menu; the counterpart that drives the level manager's `menu_comp` and `lvl_selected` inputs.
- While the level manager holds `menu_screen` high, this block:
  - takes up/down/enter key levels from the keyboard decoder;
  - moves a wrap-around level cursor;
  - runs a start countdown;
  - emits a single-cycle `menu_comp` pulse with a stable `lvl_selected`.
- Also drives the on-screen cursor and countdown digit for the menu graphics.

Parameters:
- NUM_LEVELS, 4, number of selectable levels; legal 2..4.
- COUNTDOWN_SEC, 3, seconds shown before the level starts; legal 0..15; 0 skips the countdown.
- IDLE_TIMEOUT_SEC, 10, seconds with no key press before the current cursor is auto-confirmed; legal 0..15; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- one_sec  in  1  single-cycle strobe, synchronous to clk, once per second
- menu_screen  in  1  high while the level manager shows the menu
- key_up  in  1  level, high while pressed
- key_down  in  1  level, high while pressed
- key_enter  in  1  level, high while pressed
- menu_comp  out  1  one-cycle pulse: selection confirmed
- lvl_selected  out  2  current cursor / chosen level
- countdown_val  out  4  remaining countdown seconds, for display
- countdown_active  out  1  high in COUNTDOWN

Behaviour:
- Reset values: state=IDLE, `menu_comp`=0, `lvl_selected`=0, `countdown_val`=0, `countdown_active`=0, idle counter=0, key history regs=0.
- All outputs are registered.
- Key press = rising edge of the key level (key & ~key_d). Holding a key produces exactly one press.
- IDLE:
  - Enter SELECT on the first cycle `menu_screen`=1.
  - Key history keeps updating in IDLE, so a key already held at entry does not count as a press.
- SELECT:
  - enter press has priority: go to COUNTDOWN, load `countdown_val`=COUNTDOWN_SEC; `lvl_selected` unchanged even if up/down are pressed in the same cycle.
  - If COUNTDOWN_SEC=0, go directly to DONE.
  - up press only: `lvl_selected` = (lvl==0) ? NUM_LEVELS-1 : lvl-1.
  - down press only: `lvl_selected` = (lvl==NUM_LEVELS-1) ? 0 : lvl+1.
  - up and down pressed together: no change.
  - Idle counter: any press clears it; otherwise it increments on `one_sec`. When it reaches IDLE_TIMEOUT_SEC (nonzero), treat as an enter press.
- COUNTDOWN:
  - `countdown_active`=1. Keys are ignored.
  - On `one_sec`, `countdown_val` decrements.
  - A `one_sec` arriving while `countdown_val`==1 sets it to 0 and goes to DONE.
  - A `one_sec` in the entry cycle counts; the first displayed second may be short.
- DONE:
  - `menu_comp`=1 for exactly that one cycle, then go to WAIT_EXIT.
  - `lvl_selected` is held constant from the enter press until the next SELECT entry.
- WAIT_EXIT: remain until `menu_screen`=0, then go to IDLE. A `menu_comp` pulse is never repeated within one menu session.
- `menu_screen` falling in SELECT or COUNTDOWN: abort to IDLE, no pulse, clear `countdown_val`, clear `countdown_active`. Keep `lvl_selected`.
- `lvl_selected` persists across menu sessions; it is only cleared by reset.
- Reset mid-operation: immediate asynchronous return to all reset values.

Optional Feature:
- Macro: LEVEL_MENU_AUTO_ADVANCE_EN.
- Defined:
  - Adds input port `level_comp` (1 bit, one-cycle pulse).
  - A pulse in any state except SELECT increments `lvl_selected`, saturating at NUM_LEVELS-1, so the next menu opens on the following level.
  - In SELECT the pulse is ignored.
- Undefined: the port is absent and the cursor changes only via keys.

Decomposition:
- Package `bumpy_menu_pkg`:
  - `menu_state_t` enum: IDLE, SELECT, COUNTDOWN, DONE, WAIT_EXIT.
  - LVL_W=2, CNT_W=4.
  - Shared with the menu graphics block.
- Sub-module `key_edge_detect`: one register plus AND; async reset; instantiated three times, once each for up, down and enter.

Test Plan:
- Reset, then `menu_screen`=1, down pressed 3x, enter → `lvl_selected` 0→1→2→3; `countdown_val` 3,2,1,0 on successive `one_sec`; single `menu_comp` pulse after third `one_sec`.
- In SELECT at lvl 0, press up → `lvl_selected`=3 (NUM_LEVELS=4); press down at 3 → 0.
- Enter held across IDLE→SELECT entry → no countdown. Release and re-press → countdown starts. Enter plus down in the same cycle → lvl unchanged, countdown starts.
- No keys, 10 `one_sec` strobes in SELECT → countdown starts automatically. A press at strobe 9 → counter cleared, no auto-start at strobe 10.
- `menu_screen` dropped at `countdown_val`=2 → IDLE, `countdown_val`=0, no `menu_comp`. `menu_comp` stays 0 while `menu_screen` remains high after DONE.
- With LEVEL_MENU_AUTO_ADVANCE_EN: `level_comp` pulse in WAIT_EXIT/IDLE at lvl 1 → 2. Repeated pulses saturate at 3.
